// File: rtl/pla_cube_scheduler.sv
// pla_cube_scheduler: one 17-input cube matcher time-multiplexed over a
// programmable table of NCUBES product terms. Each accepted vector is tested
// against one cube per cycle; the result is the OR of matches plus the lowest
// matching index.
// Optional build macro: PLA_SCHED_FULLSCAN_EN -- disables early exit, always
// scans every entry, and adds out_hit_cnt (number of matching cubes).
module pla_cube_scheduler #(
  parameter  int NIN    = 17,
  parameter  int NCUBES = 16,
  localparam int CW     = $clog2(NCUBES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NIN-1:0] in_vec,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_addr,
  input  logic [NIN-1:0] cfg_care,
  input  logic [NIN-1:0] cfg_val,
  input  logic          cfg_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_y,
  output logic [CW-1:0] out_hit_idx,
`ifdef PLA_SCHED_FULLSCAN_EN
  output logic [CW:0]   out_hit_cnt,
`endif
  output logic          busy
);

  // Table is sized to the full index space so a non-power-of-2 NCUBES never
  // produces an out-of-range write; entries >= NCUBES are simply never scanned.
  localparam int DEPTH = 1 << CW;

`ifdef PLA_SCHED_FULLSCAN_EN
  localparam bit FULLSCAN = 1'b1;
`else
  localparam bit FULLSCAN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t state_q, state_d;

  logic [DEPTH-1:0][NIN-1:0] care_q;
  logic [DEPTH-1:0][NIN-1:0] val_q;
  logic [DEPTH-1:0]          en_q;

  logic [NIN-1:0] vec_q;
  logic [CW-1:0]  idx_q;
  logic           y_q;
  logic [CW-1:0]  hit_idx_q;

  logic accept, tbl_wr, match, last;

  assign in_ready = (state_q == IDLE) && !cfg_we;
  assign accept   = in_valid && in_ready;
  assign tbl_wr   = cfg_we && (state_q == IDLE);
  assign last     = (idx_q == CW'(NCUBES - 1));
  assign match    = en_q[idx_q] && (((vec_q ^ val_q[idx_q]) & care_q[idx_q]) == '0);

  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign out_y       = y_q;
  assign out_hit_idx = hit_idx_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: early exit on first hit unless full scan is built in
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EVAL;
      EVAL:    if (last || (!FULLSCAN && match)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Enable bits reset to 0; table writes only land while IDLE
  always_ff @(posedge clk) begin
    if (rst)         en_q <= '0;
    else if (tbl_wr) en_q[cfg_addr] <= cfg_en;
  end

  // Care/value payload needs no reset: gated by en_q on the match path
  always_ff @(posedge clk) begin
    if (tbl_wr) begin
      care_q[cfg_addr] <= cfg_care;
      val_q[cfg_addr]  <= cfg_val;
    end
  end

  // Datapath: latch vector, walk the index, record the lowest hit.
  // Result registers are cleared on accept, so a no-hit scan ends with y=0, idx=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q     <= '0;
      idx_q     <= '0;
      y_q       <= 1'b0;
      hit_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          vec_q     <= in_vec;
          idx_q     <= '0;
          y_q       <= 1'b0;
          hit_idx_q <= '0;
        end
        EVAL: begin
          if (match && !y_q) begin
            y_q       <= 1'b1;
            hit_idx_q <= idx_q;
          end
          if (!last) idx_q <= idx_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef PLA_SCHED_FULLSCAN_EN
  logic [CW:0] cnt_q;

  // Count of matching cubes over the full scan
  always_ff @(posedge clk) begin
    if (rst)                              cnt_q <= '0;
    else if (state_q == IDLE && accept)   cnt_q <= '0;
    else if (state_q == EVAL && match)    cnt_q <= cnt_q + (CW+1)'(1);
  end

  assign out_hit_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pla_cube_scheduler.sv
// Self-checking bench for pla_cube_scheduler: reference table model plus an
// expectation queue; each scenario task compares DUT results inline.
module tb_pla_cube_scheduler;
  localparam int NIN    = 17;
  localparam int NCUBES = 16;
  localparam int CW     = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [NIN-1:0] in_vec = '0;
  logic           cfg_we = 1'b0;
  logic [CW-1:0]  cfg_addr = '0;
  logic [NIN-1:0] cfg_care = '0;
  logic [NIN-1:0] cfg_val = '0;
  logic           cfg_en = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           out_y;
  logic [CW-1:0]  out_hit_idx;
  logic           busy;
`ifdef PLA_SCHED_FULLSCAN_EN
  logic [CW:0]    out_hit_cnt;
`endif

  pla_cube_scheduler #(.NIN(NIN), .NCUBES(NCUBES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_care(cfg_care),
    .cfg_val(cfg_val), .cfg_en(cfg_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_hit_idx(out_hit_idx),
`ifdef PLA_SCHED_FULLSCAN_EN
    .out_hit_cnt(out_hit_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit y;
    int idx;
    int cnt;
    int lat;
  } res_t;

  res_t sbq[$];

  logic [NIN-1:0] m_care [NCUBES];
  logic [NIN-1:0] m_val  [NCUBES];
  bit             m_en   [NCUBES];

  // Reference: linear scan of the model table
  function automatic res_t model(input logic [NIN-1:0] v);
    res_t e;
    e.y = 1'b0; e.idx = 0; e.cnt = 0; e.lat = NCUBES + 1;
    for (int i = 0; i < NCUBES; i++) begin
      if (m_en[i] && (((v ^ m_val[i]) & m_care[i]) == '0)) begin
        if (!e.y) begin
          e.y = 1'b1;
          e.idx = i;
`ifndef PLA_SCHED_FULLSCAN_EN
          e.lat = i + 2;
`endif
        end
        e.cnt++;
      end
    end
    return e;
  endfunction

  // Table write in IDLE, mirrored into the model
  task automatic write_cfg(input int a, input logic [NIN-1:0] c, input logic [NIN-1:0] v, input bit e);
    cfg_we = 1'b1; cfg_addr = CW'(a); cfg_care = c; cfg_val = v; cfg_en = e;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_care[a] = c; m_val[a] = v; m_en[a] = e;
  endtask

  // Offer a vector, measure latency from the accept edge, then handshake
  task automatic run_vec(input logic [NIN-1:0] v, output res_t o);
    int n;
    o.y = 1'b0; o.idx = 0; o.cnt = 0; o.lat = -1;
    in_vec = v; in_valid = 1'b1; #1;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    if (out_valid) begin
      o.y = out_y; o.idx = int'(out_hit_idx); o.lat = n;
`ifdef PLA_SCHED_FULLSCAN_EN
      o.cnt = int'(out_hit_cnt);
`endif
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < NCUBES; i++) m_en[i] = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_y !== 1'b0) begin errors++; $display("FAIL reset_out_y got %b want 0", out_y); end
    checks++; if (out_hit_idx !== '0) begin errors++; $display("FAIL reset_hit_idx got %0d want 0", out_hit_idx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_vectors(input string name, input logic [NIN-1:0] v);
    res_t o, e;
    sbq.push_back(model(v));
    run_vec(v, o);
    e = sbq.pop_front();
    checks++;
    if (o.y !== e.y || o.idx != e.idx || o.lat != e.lat
`ifdef PLA_SCHED_FULLSCAN_EN
        || o.cnt != e.cnt
`endif
       ) begin
      errors++;
      $display("FAIL %s vec=%h got y=%0d idx=%0d cnt=%0d lat=%0d want y=%0d idx=%0d cnt=%0d lat=%0d",
               name, v, o.y, o.idx, o.cnt, o.lat, e.y, e.idx, e.cnt, e.lat);
    end
  endtask

  task automatic test_no_hit;
    test_vectors("no_hit", 17'h1FA59);
  endtask

  task automatic test_single_hit;
    write_cfg(3, 17'h1FFFF, 17'h1FA59, 1'b1);
    test_vectors("single_hit", 17'h1FA59);
    test_vectors("single_miss", 17'h1FA58);
  endtask

  task automatic test_multi_hit;
    write_cfg(2, 17'h00000, 17'h00000, 1'b1);
    test_vectors("multi_hit", 17'h1FA59);
  endtask

  // Stall in DONE; table writes during EVAL/DONE must be dropped
  task automatic test_stall;
    res_t e;
    int n;
    e = model(17'h1FA59);
    sbq.push_back(e);
    in_vec = 17'h1FA59; in_valid = 1'b1; #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = 0; cfg_care = '0; cfg_val = '0; cfg_en = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_reach_done timeout"); end
    cfg_we = 1'b1; cfg_addr = 1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    e = sbq.pop_front();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_y !== e.y || int'(out_hit_idx) != e.idx || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got v=%b y=%b idx=%0d rdy=%b want v=1 y=%0d idx=%0d rdy=0",
                 i, out_valid, out_y, out_hit_idx, in_ready, e.y, e.idx);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    test_vectors("stall_rerun", 17'h1FA59);
  endtask

  // Same-cycle cfg_we and in_valid: write wins, vector waits
  task automatic test_cfg_collision;
    cfg_we = 1'b1; cfg_addr = 1; cfg_care = '0; cfg_val = '0; cfg_en = 1'b1;
    in_vec = 17'h00F0F; in_valid = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL collide_in_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    m_care[1] = '0; m_val[1] = '0; m_en[1] = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL collide_busy got %b want 0", busy); end
    test_vectors("collide_write_taken", 17'h00F0F);
  endtask

  // Reset mid-evaluation aborts and disables every entry
  task automatic test_reset_in_eval;
    in_vec = 17'h1FA59; in_valid = 1'b1; #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NCUBES; i++) m_en[i] = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_eval_busy got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_eval_out_valid got %b want 0", out_valid); end
    checks++; if (out_y !== 1'b0) begin errors++; $display("FAIL rst_eval_out_y got %b want 0", out_y); end
    test_vectors("rst_eval_disabled", 17'h1FA59);
  endtask

  task automatic test_random;
    logic [NIN-1:0] v;
    for (int i = 0; i < NCUBES; i++)
      write_cfg(i, NIN'($urandom & $urandom & $urandom), NIN'($urandom), bit'($urandom_range(0, 1)));
    for (int k = 0; k < 10; k++) begin
      v = NIN'($urandom);
      test_vectors("random", v);
    end
  endtask

  initial begin
    test_reset();
    test_no_hit();
    test_single_hit();
    test_multi_hit();
    test_stall();
    test_cfg_collision();
    test_reset_in_eval();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
